// File: rtl/ddr2_mcb.sv
// Purpose : DDR2 memory-controller-block model: p0 command/write/read FIFOs feeding a 1024x32 on-chip RAM via a 3-state engine.
// Latency : accepted read (idle engine) at edge E0 -> first word at read-FIFO head after edge E3; writes drain one word per clock.
// Backpres: cmd_full/wr_full held high until calibration completes and when FIFOs fill; read words arriving at a full read FIFO are dropped.
// Optional: define DDR2_MCB_ERROR_FLAGS_EN for sticky wr_error/rd_error/rd_overflow/wr_underrun; otherwise those outputs are tied 0.

module ddr2_mcb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage write; contents are don't-care while empty, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_dat;
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module ddr2_mcb #(
    parameter int CALIB_CYCLES  = 64,
    parameter int MEM_ADDR_BITS = 10,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic        c3_sys_clk,
    input  logic        c3_sys_rst_n,
    output logic        c3_rst0,
    output logic        c3_calib_done,
    input  logic        c3_p0_cmd_en,
    input  logic [2:0]  c3_p0_cmd_instr,
    input  logic [5:0]  c3_p0_cmd_bl,
    input  logic [29:0] c3_p0_cmd_byte_addr,
    output logic        c3_p0_cmd_empty,
    output logic        c3_p0_cmd_full,
    input  logic        c3_p0_wr_en,
    input  logic [3:0]  c3_p0_wr_mask,
    input  logic [31:0] c3_p0_wr_data,
    output logic        c3_p0_wr_full,
    output logic        c3_p0_wr_empty,
    output logic [6:0]  c3_p0_wr_count,
    output logic        c3_p0_wr_underrun,
    output logic        c3_p0_wr_error,
    input  logic        c3_p0_rd_en,
    output logic [31:0] c3_p0_rd_data,
    output logic        c3_p0_rd_full,
    output logic        c3_p0_rd_empty,
    output logic [6:0]  c3_p0_rd_count,
    output logic        c3_p0_rd_overflow,
    output logic        c3_p0_rd_error
);
    localparam int CAL_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALIB_CYCLES - 1);
    localparam int CMD_W = 3 + 6 + MEM_ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    logic [1:0]               r_rst_sync;
    logic [CAL_W-1:0]         r_calib_cnt;
    logic                     r_calib_done;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [MEM_ADDR_BITS-1:0] r_addr;
    logic [5:0]               r_len;
    logic [31:0]              r_mem [2**MEM_ADDR_BITS];
    logic [31:0]              r_ram_q;
    logic                     r_rdq_vld;

    logic                     w_cmd_push;
    logic                     w_cmd_pop;
    logic [CMD_W-1:0]         w_cmd_head;
    logic                     w_cmd_fifo_full;
    logic                     w_cmd_empty;
    logic [2:0]               w_unused_cmd_cnt;
    logic                     w_unused_addr;
    logic [2:0]               w_cmd_instr;
    logic [5:0]               w_cmd_bl;
    logic [MEM_ADDR_BITS-1:0] w_cmd_addr;
    logic                     w_cmd_is_wr;
    logic                     w_cmd_is_rd;

    logic                     w_wr_push;
    logic                     w_wr_pop;
    logic [35:0]              w_wr_head;
    logic                     w_wr_fifo_full;
    logic                     w_wr_ready;

    logic                     w_rd_push;
    logic [31:0]              w_rd_head;
    logic                     w_rd_empty;

    logic                     w_load;
    logic                     w_step;
    logic                     w_ram_re;

    assign c3_rst0       = r_rst_sync[1];
    assign c3_calib_done = r_calib_done;

    // Two-flop reset synchroniser: asserts immediately, releases on the 2nd edge.
    always_ff @(posedge c3_sys_clk or negedge c3_sys_rst_n) begin
        if (!c3_sys_rst_n) r_rst_sync <= 2'b11;
        else               r_rst_sync <= {r_rst_sync[0], 1'b0};
    end

    // Calibration timer: counts clocks after the user reset drops, then latches done.
    always_ff @(posedge c3_sys_clk or negedge c3_sys_rst_n) begin
        if (!c3_sys_rst_n) begin
            r_calib_cnt  <= '0;
            r_calib_done <= 1'b0;
        end else if (!r_rst_sync[1] && !r_calib_done) begin
            if (r_calib_cnt == CAL_LAST) r_calib_done <= 1'b1;
            else                         r_calib_cnt  <= r_calib_cnt + 1'b1;
        end
    end

    // Command queue: only the word address is kept; byte-lane bits and upper bits are unused.
    assign w_unused_addr  = ^{c3_p0_cmd_byte_addr[29:MEM_ADDR_BITS+2], c3_p0_cmd_byte_addr[1:0]};
    assign c3_p0_cmd_full = ~r_calib_done | w_cmd_fifo_full;
    assign w_cmd_push     = c3_p0_cmd_en & ~c3_p0_cmd_full;
    assign c3_p0_cmd_empty = w_cmd_empty;

    ddr2_mcb_fifo #(.WIDTH(CMD_W), .DEPTH(4), .CW(3)) u_cmd_fifo (
        .i_clk   (c3_sys_clk),
        .i_rst_n (c3_sys_rst_n),
        .i_push  (w_cmd_push),
        .i_dat   ({c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr[MEM_ADDR_BITS+1:2]}),
        .i_pop   (w_cmd_pop),
        .o_dat   (w_cmd_head),
        .o_count (w_unused_cmd_cnt),
        .o_full  (w_cmd_fifo_full),
        .o_empty (w_cmd_empty)
    );

    assign {w_cmd_instr, w_cmd_bl, w_cmd_addr} = w_cmd_head;
    assign w_cmd_is_wr = ~w_cmd_instr[2] & ~w_cmd_instr[0];
    assign w_cmd_is_rd = ~w_cmd_instr[2] &  w_cmd_instr[0];

    // Write data queue: entries carry {mask, data}.
    assign c3_p0_wr_full = ~r_calib_done | w_wr_fifo_full;
    assign w_wr_push     = c3_p0_wr_en & ~c3_p0_wr_full;

    ddr2_mcb_fifo #(.WIDTH(36), .DEPTH(FIFO_DEPTH), .CW(7)) u_wr_fifo (
        .i_clk   (c3_sys_clk),
        .i_rst_n (c3_sys_rst_n),
        .i_push  (w_wr_push),
        .i_dat   ({c3_p0_wr_mask, c3_p0_wr_data}),
        .i_pop   (w_wr_pop),
        .o_dat   (w_wr_head),
        .o_count (c3_p0_wr_count),
        .o_full  (w_wr_fifo_full),
        .o_empty (c3_p0_wr_empty)
    );

    // Once enough data is queued for the remaining beats, this stays true for the whole burst.
    assign w_wr_ready = ({1'b0, r_len} < c3_p0_wr_count);

    // Read data queue: first-word-fall-through head, zero while empty.
    assign w_rd_push      = r_rdq_vld & ~c3_p0_rd_full;
    assign c3_p0_rd_empty = w_rd_empty;
    assign c3_p0_rd_data  = w_rd_empty ? 32'd0 : w_rd_head;

    ddr2_mcb_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH), .CW(7)) u_rd_fifo (
        .i_clk   (c3_sys_clk),
        .i_rst_n (c3_sys_rst_n),
        .i_push  (w_rd_push),
        .i_dat   (r_ram_q),
        .i_pop   (c3_p0_rd_en),
        .o_dat   (w_rd_head),
        .o_count (c3_p0_rd_count),
        .o_full  (c3_p0_rd_full),
        .o_empty (w_rd_empty)
    );

    // Engine state register.
    always_ff @(posedge c3_sys_clk or negedge c3_sys_rst_n) begin
        if (!c3_sys_rst_n) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    // Engine next-state and per-cycle strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        w_wr_pop    = 1'b0;
        w_ram_re    = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_cmd_empty) begin
                    w_cmd_pop = 1'b1;
                    if (w_cmd_is_wr) begin
                        w_state_nxt = S_WRITE;
                        w_load      = 1'b1;
                    end else if (w_cmd_is_rd) begin
                        w_state_nxt = S_READ;
                        w_load      = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (w_wr_ready) begin
                    w_wr_pop = 1'b1;
                    w_step   = 1'b1;
                    if (r_len == 6'd0) w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                w_ram_re = 1'b1;
                w_step   = 1'b1;
                if (r_len == 6'd0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst address/length tracking; address wraps at the RAM size.
    always_ff @(posedge c3_sys_clk or negedge c3_sys_rst_n) begin
        if (!c3_sys_rst_n) begin
            r_addr <= '0;
            r_len  <= '0;
        end else if (w_load) begin
            r_addr <= w_cmd_addr;
            r_len  <= w_cmd_bl;
        end else if (w_step) begin
            r_addr <= r_addr + 1'b1;
            r_len  <= r_len - 1'b1;
        end
    end

    // RAM port: byte-masked writes (mask bit 1 keeps the old byte) and registered reads.
    always_ff @(posedge c3_sys_clk) begin
        if (w_wr_pop) begin
            for (int b = 0; b < 4; b++) begin
                if (!w_wr_head[32+b]) r_mem[r_addr][8*b +: 8] <= w_wr_head[8*b +: 8];
            end
        end
        if (w_ram_re) r_ram_q <= r_mem[r_addr];
    end

    // Read pipeline valid: marks r_ram_q as a word to hand to the read queue.
    always_ff @(posedge c3_sys_clk or negedge c3_sys_rst_n) begin
        if (!c3_sys_rst_n) r_rdq_vld <= 1'b0;
        else               r_rdq_vld <= w_ram_re;
    end

`ifdef DDR2_MCB_ERROR_FLAGS_EN
    logic r_wr_error;
    logic r_rd_error;
    logic r_rd_overflow;
    logic r_wr_underrun;
    logic r_wr_first;

    // Sticky error flags, cleared only by reset; r_wr_first marks the first WRITE cycle.
    always_ff @(posedge c3_sys_clk or negedge c3_sys_rst_n) begin
        if (!c3_sys_rst_n) begin
            r_wr_error    <= 1'b0;
            r_rd_error    <= 1'b0;
            r_rd_overflow <= 1'b0;
            r_wr_underrun <= 1'b0;
            r_wr_first    <= 1'b0;
        end else begin
            r_wr_first <= w_load & w_cmd_is_wr;
            if (c3_p0_wr_en && c3_p0_wr_full) r_wr_error    <= 1'b1;
            if (c3_p0_rd_en && w_rd_empty)    r_rd_error    <= 1'b1;
            if (r_rdq_vld && c3_p0_rd_full)   r_rd_overflow <= 1'b1;
            if (r_wr_first && !w_wr_ready)    r_wr_underrun <= 1'b1;
        end
    end

    assign c3_p0_wr_error    = r_wr_error;
    assign c3_p0_rd_error    = r_rd_error;
    assign c3_p0_rd_overflow = r_rd_overflow;
    assign c3_p0_wr_underrun = r_wr_underrun;
`else
    assign c3_p0_wr_error    = 1'b0;
    assign c3_p0_rd_error    = 1'b0;
    assign c3_p0_rd_overflow = 1'b0;
    assign c3_p0_wr_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_mcb.sv
// Directed bench for ddr2_mcb: reset/calibration timing, write/read bursts, byte masks, address wrap,
// command-queue backpressure, read overflow and reset abort. Inputs change 1 ns after the rising edge,
// outputs are sampled there too.
module tb_ddr2_mcb;
`ifdef DDR2_MCB_ERROR_FLAGS_EN
    localparam logic FLAG_ON = 1'b1;
`else
    localparam logic FLAG_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        rst0;
    logic        calib_done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_addr;
    logic        cmd_empty;
    logic        cmd_full;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        wr_empty;
    logic [6:0]  wr_count;
    logic        wr_underrun;
    logic        wr_error;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_full;
    logic        rd_empty;
    logic [6:0]  rd_count;
    logic        rd_overflow;
    logic        rd_error;

    int n_checks = 0;
    int n_err    = 0;

    ddr2_mcb dut (
        .c3_sys_clk          (clk),
        .c3_sys_rst_n        (rst_n),
        .c3_rst0             (rst0),
        .c3_calib_done       (calib_done),
        .c3_p0_cmd_en        (cmd_en),
        .c3_p0_cmd_instr     (cmd_instr),
        .c3_p0_cmd_bl        (cmd_bl),
        .c3_p0_cmd_byte_addr (cmd_addr),
        .c3_p0_cmd_empty     (cmd_empty),
        .c3_p0_cmd_full      (cmd_full),
        .c3_p0_wr_en         (wr_en),
        .c3_p0_wr_mask       (wr_mask),
        .c3_p0_wr_data       (wr_data),
        .c3_p0_wr_full       (wr_full),
        .c3_p0_wr_empty      (wr_empty),
        .c3_p0_wr_count      (wr_count),
        .c3_p0_wr_underrun   (wr_underrun),
        .c3_p0_wr_error      (wr_error),
        .c3_p0_rd_en         (rd_en),
        .c3_p0_rd_data       (rd_data),
        .c3_p0_rd_full       (rd_full),
        .c3_p0_rd_empty      (rd_empty),
        .c3_p0_rd_count      (rd_count),
        .c3_p0_rd_overflow   (rd_overflow),
        .c3_p0_rd_error      (rd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_data = d; wr_mask = m;
        step();
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] ins, input logic [5:0] bl, input logic [29:0] a);
        cmd_en = 1'b1; cmd_instr = ins; cmd_bl = bl; cmd_addr = a;
        step();
        cmd_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        for (int k = 0; k < 200; k++) begin
            if (!rd_empty) break;
            step();
        end
        chk({tag, "_avail"}, 32'(rd_empty), 32'd0);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst_n = 1'b0; cmd_en = 1'b0; cmd_instr = 3'd0; cmd_bl = 6'd0; cmd_addr = 30'd0;
        wr_en = 1'b0; wr_mask = 4'd0; wr_data = 32'd0; rd_en = 1'b0;
        wait_cycles(3);

        // Reset state
        chk("rst_rst0",      32'(rst0),       32'd1);
        chk("rst_calib",     32'(calib_done), 32'd0);
        chk("rst_cmd_empty", 32'(cmd_empty),  32'd1);
        chk("rst_cmd_full",  32'(cmd_full),   32'd1);
        chk("rst_wr_full",   32'(wr_full),    32'd1);
        chk("rst_wr_empty",  32'(wr_empty),   32'd1);
        chk("rst_rd_empty",  32'(rd_empty),   32'd1);
        chk("rst_rd_full",   32'(rd_full),    32'd0);
        chk("rst_wr_count",  32'(wr_count),   32'd0);
        chk("rst_rd_count",  32'(rd_count),   32'd0);
        chk("rst_rd_data",   rd_data,         32'd0);
        chk("rst_flags",     32'({wr_error, rd_error, rd_overflow, wr_underrun}), 32'd0);

        // Reset release and calibration timing
        rst_n = 1'b1;
        step();
        chk("rst0_edge1", 32'(rst0), 32'd1);
        step();
        chk("rst0_edge2", 32'(rst0), 32'd0);
        wait_cycles(62);
        send_cmd(3'b001, 6'd0, 30'h0);
        chk("calib_63",          32'(calib_done), 32'd0);
        chk("cmd_full_precal",   32'(cmd_full),   32'd1);
        chk("cmd_ignored_precal", 32'(cmd_empty), 32'd1);
        step();
        chk("calib_64",        32'(calib_done), 32'd1);
        chk("cmd_full_postcal", 32'(cmd_full),  32'd0);
        chk("wr_full_postcal",  32'(wr_full),   32'd0);

        // 32-word burst write then read back at byte address 0x100
        for (int i = 0; i < 32; i++) push_wr(32'h600D0001 + 32'(i), 4'b0000);
        chk("wr_count_32", 32'(wr_count), 32'd32);
        send_cmd(3'b000, 6'd31, 30'h100);
        send_cmd(3'b001, 6'd31, 30'h100);
        for (int i = 0; i < 32; i++) pop_chk("burst", 32'h600D0001 + 32'(i));
        chk("wr_empty_after", 32'(wr_empty), 32'd1);

        // Byte masks: 1010 keeps bytes 1,3 -> FF00FF00; 0101 keeps bytes 0,2 -> 00FF00FF
        push_wr(32'hFFFFFFFF, 4'b0000);
        push_wr(32'h00000000, 4'b1010);
        push_wr(32'hFFFFFFFF, 4'b0000);
        push_wr(32'h00000000, 4'b0101);
        send_cmd(3'b000, 6'd0, 30'h200);
        send_cmd(3'b010, 6'd0, 30'h200);
        send_cmd(3'b000, 6'd0, 30'h204);
        send_cmd(3'b000, 6'd0, 30'h204);
        wait_cycles(10);
        send_cmd(3'b001, 6'd0, 30'h200);
        chk("lat_e0", 32'(rd_empty), 32'd1);
        step();
        chk("lat_e1", 32'(rd_empty), 32'd1);
        step();
        chk("lat_e2", 32'(rd_empty), 32'd1);
        step();
        chk("lat_e3", 32'(rd_empty), 32'd0);
        pop_chk("mask_1010", 32'hFF00FF00);
        send_cmd(3'b011, 6'd0, 30'h204);
        pop_chk("mask_0101", 32'h00FF00FF);

        // Address wrap: words at 1022,1023,0,1; byte lanes of address ignored on readback
        for (int i = 0; i < 4; i++) push_wr(32'hA0000001 + 32'(i), 4'b0000);
        send_cmd(3'b000, 6'd3, 30'hFF8);
        send_cmd(3'b001, 6'd1, 30'h000);
        pop_chk("wrap_w0", 32'hA0000003);
        pop_chk("wrap_w1", 32'hA0000004);
        send_cmd(3'b001, 6'd3, 30'hFFB);
        for (int i = 0; i < 4; i++) pop_chk("wrap_rb", 32'hA0000001 + 32'(i));
        send_cmd(3'b111, 6'd0, 30'h0);
        wait_cycles(5);
        chk("bad_instr_no_data", 32'(rd_empty), 32'd1);
        chk("underrun_none", 32'(wr_underrun), 32'd0);

        // Command queue backpressure with the engine blocked on write data
        send_cmd(3'b000, 6'd0, 30'h300);
        wait_cycles(3);
        chk("blk_cmd_empty", 32'(cmd_empty), 32'd1);
        chk("underrun_set", 32'(wr_underrun), 32'(FLAG_ON));
        send_cmd(3'b000, 6'd0, 30'h304);
        send_cmd(3'b000, 6'd0, 30'h308);
        send_cmd(3'b000, 6'd0, 30'h30C);
        chk("cmd_not_full_3", 32'(cmd_full), 32'd0);
        send_cmd(3'b000, 6'd0, 30'h310);
        chk("cmd_full_4", 32'(cmd_full), 32'd1);
        send_cmd(3'b001, 6'd0, 30'h300);
        chk("cmd_full_5", 32'(cmd_full), 32'd1);
        for (int i = 0; i < 5; i++) push_wr(32'hD0000000 + 32'(i), 4'b0000);
        wait_cycles(30);
        chk("blk_drained_cmd", 32'(cmd_empty), 32'd1);
        chk("blk_drained_wr",  32'(wr_empty),  32'd1);
        chk("fifth_ignored",   32'(rd_empty),  32'd1);
        send_cmd(3'b001, 6'd4, 30'h300);
        for (int i = 0; i < 5; i++) pop_chk("blk_rb", 32'hD0000000 + 32'(i));

        // Read error and read overflow
        chk("rd_error_clear", 32'(rd_error), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("rd_error_set", 32'(rd_error), 32'(FLAG_ON));
        send_cmd(3'b001, 6'd63, 30'h100);
        send_cmd(3'b001, 6'd0, 30'h100);
        wait_cycles(100);
        chk("ovf_rd_count", 32'(rd_count), 32'd64);
        chk("ovf_rd_full",  32'(rd_full),  32'd1);
        chk("ovf_flag",     32'(rd_overflow), 32'(FLAG_ON));
        chk("ovf_head",     rd_data, 32'h600D0001);
        chk("wr_error_clear", 32'(wr_error), 32'd0);

        // Reset mid-operation: queued write command and read data are discarded
        send_cmd(3'b000, 6'd5, 30'h380);
        wait_cycles(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rst0",     32'(rst0),       32'd1);
        chk("mid_rst_calib",    32'(calib_done), 32'd0);
        chk("mid_rst_rd_empty", 32'(rd_empty),   32'd1);
        chk("mid_rst_rd_count", 32'(rd_count),   32'd0);
        chk("mid_rst_rd_full",  32'(rd_full),    32'd0);
        chk("mid_rst_rd_data",  rd_data,         32'd0);
        chk("mid_rst_flags",    32'({wr_error, rd_error, rd_overflow, wr_underrun}), 32'd0);
        step();
        rst_n = 1'b1;
        wait_cycles(66);
        chk("recal_done", 32'(calib_done), 32'd1);
        chk("recal_cmd_empty", 32'(cmd_empty), 32'd1);
        push_wr(32'hE0000001, 4'b0000);
        wait_cycles(5);
        chk("old_cmd_discarded", 32'(wr_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
